// File: rtl/fence_t_ctrl_pkg.sv
// Shared types, constants and helpers for the fence.t controller.
package fence_t_ctrl_pkg;

  // Architectural address width of PCs and restart addresses.
  localparam int unsigned VLEN = 64;

  // Drain and reset cycle counts are bounded at 256, so 8 bits hold count-1.
  localparam int unsigned CntW = 8;

  localparam logic [1:0] PrivLvlU = 2'b00;
  localparam logic [1:0] PrivLvlM = 2'b11;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFlush    = 3'd1,
    StDrain    = 3'd2,
    StPad      = 3'd3,
    StRstUarch = 3'd4
  } fence_t_state_e;

  typedef enum logic [1:0] {
    PadSrcIrq    = 2'd0,
    PadSrcUmode  = 2'd1,
    PadSrcNone   = 2'd2,
    PadSrcIrqAlt = 2'd3
  } pad_src_e;

  // Event that reloads the pad counter for the selected source.
  function automatic logic pad_event(input pad_src_e   src,
                                     input logic       irq,
                                     input logic       irq_q,
                                     input logic [1:0] priv,
                                     input logic [1:0] priv_q);
    logic ev;
    case (src)
      PadSrcUmode: ev = (priv_q == PrivLvlU) && (priv != PrivLvlU);
      PadSrcNone:  ev = 1'b0;
      default:     ev = irq && !irq_q;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/fence_t_ctrl_counter.sv
// Generic up/down counter with synchronous clear and load.
module fence_t_ctrl_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             down_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] cnt_q;

  // Priority: clear, then load, then count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= d_i;
    end else if (en_i) begin
      cnt_q <= down_i ? cnt_q - Width'(1) : cnt_q + Width'(1);
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/fence_t_ctrl.sv
// fence.t sequencer: flush caches, drain traffic, pad timing, then microreset.
module fence_t_ctrl
  import fence_t_ctrl_pkg::*;
#(
  parameter int unsigned NrChannels     = 2,
  parameter int unsigned DrainCycles    = 16,
  parameter int unsigned PadWidth       = 32,
  parameter int unsigned RstCycles      = 16,
  parameter int unsigned InitHoldCycles = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fence_t_i,
  input  logic [VLEN-1:0]       pc_commit_i,
  input  logic [VLEN-1:0]       boot_addr_i,
  output logic [NrChannels-1:0] flush_req_o,
  input  logic [NrChannels-1:0] flush_ack_i,
  input  logic [NrChannels-1:0] busy_i,
  input  logic [PadWidth-1:0]   pad_i,
  input  logic [1:0]            src_sel_i,
  input  logic                  time_irq_i,
  input  logic [1:0]            priv_lvl_i,
  output logic                  halt_o,
  output logic                  stall_cache_o,
  output logic                  rst_uarch_no,
  output logic                  cache_init_no,
  output logic [VLEN-1:0]       rst_addr_o,
  output logic [PadWidth-1:0]   ceil_o,
  output logic                  ceil_valid_o,
  output logic                  done_o
);

  localparam int unsigned HoldW = (InitHoldCycles > 0) ? $clog2(InitHoldCycles + 1) : 1;

  fence_t_state_e        state_q;
  logic [NrChannels-1:0] ack_mask_q;
  logic [VLEN-1:0]       rst_addr_q;
  logic [PadWidth-1:0]   ceil_q;
  logic                  ceil_valid_q;
  logic                  done_q;
  logic                  rst_uarch_q;
  logic                  cache_init_q;
  logic [HoldW-1:0]      hold_q;
  logic                  irq_q;
  logic [1:0]            priv_q;

  logic [PadWidth-1:0]   pad_cnt;
  logic [CntW-1:0]       drain_cnt;
  logic [CntW-1:0]       rst_cnt;
  logic                  pad_load;
  logic                  drain_done;
  logic                  rst_done;
  pad_src_e              src_sel;

  assign src_sel    = pad_src_e'(src_sel_i);
  assign pad_load   = pad_event(src_sel, time_irq_i, irq_q, priv_lvl_i, priv_q);
  assign drain_done = (state_q == StDrain) && (busy_i == '0) &&
                      (drain_cnt == CntW'(DrainCycles - 1));
  assign rst_done   = (state_q == StRstUarch) && (rst_cnt == CntW'(RstCycles - 1));

  // Pad counter free-runs regardless of FSM state.
  fence_t_ctrl_counter #(
    .Width (PadWidth)
  ) u_pad_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (1'b0),
    .load_i  (pad_load),
    .en_i    (pad_cnt != '0),
    .down_i  (1'b1),
    .d_i     (pad_i),
    .q_o     (pad_cnt)
  );

  // Counts consecutive all-idle DRAIN cycles; zero whenever not draining.
  fence_t_ctrl_counter #(
    .Width (CntW)
  ) u_drain_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i ((state_q != StDrain) || (busy_i != '0)),
    .load_i  (1'b0),
    .en_i    (1'b1),
    .down_i  (1'b0),
    .d_i     ('0),
    .q_o     (drain_cnt)
  );

  // Counts cycles spent holding the microarchitectural reset.
  fence_t_ctrl_counter #(
    .Width (CntW)
  ) u_rst_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (state_q != StRstUarch),
    .load_i  (1'b0),
    .en_i    (1'b1),
    .down_i  (1'b0),
    .d_i     ('0),
    .q_o     (rst_cnt)
  );

  // Registered copies used for pad-event edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q  <= 1'b0;
      priv_q <= PrivLvlM;
    end else begin
      irq_q  <= time_irq_i;
      priv_q <= priv_lvl_i;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      ack_mask_q   <= '0;
      rst_addr_q   <= boot_addr_i;
      ceil_q       <= '0;
      ceil_valid_q <= 1'b0;
      done_q       <= 1'b0;
      rst_uarch_q  <= 1'b1;
      cache_init_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      ceil_valid_q <= 1'b0;
      done_q       <= 1'b0;
      // Tail of cache_init_no after the microreset ends.
      if ((state_q != StRstUarch) && (hold_q != '0)) begin
        hold_q       <= hold_q - HoldW'(1);
        cache_init_q <= (hold_q != HoldW'(1));
      end
      case (state_q)
        StIdle: begin
          if (fence_t_i) begin
            state_q    <= StFlush;
            rst_addr_q <= pc_commit_i + VLEN'(4);
          end
        end
        StFlush: begin
          if (&(ack_mask_q | flush_ack_i)) begin
            state_q    <= StDrain;
            ack_mask_q <= '0;
          end else begin
            ack_mask_q <= ack_mask_q | flush_ack_i;
          end
        end
        StDrain: begin
          if (drain_done) begin
            state_q      <= StPad;
            ceil_q       <= (pad_cnt != '0) ? pad_i - pad_cnt : '0;
            ceil_valid_q <= 1'b1;
          end
        end
        StPad: begin
          if ((pad_cnt == '0) || (src_sel == PadSrcNone)) begin
            state_q      <= StRstUarch;
            rst_uarch_q  <= 1'b0;
            cache_init_q <= 1'b1;
            hold_q       <= '0;
          end
        end
        StRstUarch: begin
          if (rst_done) begin
            state_q      <= StIdle;
            rst_uarch_q  <= 1'b1;
            done_q       <= 1'b1;
            cache_init_q <= (InitHoldCycles != 0);
            hold_q       <= HoldW'(InitHoldCycles);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign halt_o        = (state_q != StIdle);
  assign stall_cache_o = (state_q != StIdle);
  assign flush_req_o   = (state_q == StFlush) ? ~ack_mask_q : '0;
  assign rst_uarch_no  = rst_uarch_q;
  assign cache_init_no = cache_init_q;
  assign rst_addr_o    = rst_addr_q;
  assign ceil_o        = ceil_q;
  assign ceil_valid_o  = ceil_valid_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_fence_t_ctrl.sv
// Scoreboard bench for fence_t_ctrl: directed sequences, event monitor.
module tb_fence_t_ctrl;
  import fence_t_ctrl_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b1;
  logic            fence_t_i;
  logic [63:0]     pc_commit_i;
  logic [63:0]     boot_addr_i;
  logic [1:0]      flush_req_o;
  logic [1:0]      flush_ack_i;
  logic [1:0]      busy_i;
  logic [31:0]     pad_i;
  logic [1:0]      src_sel_i;
  logic            time_irq_i;
  logic [1:0]      priv_lvl_i;
  logic            halt_o;
  logic            stall_cache_o;
  logic            rst_uarch_no;
  logic            cache_init_no;
  logic [63:0]     rst_addr_o;
  logic [31:0]     ceil_o;
  logic            ceil_valid_o;
  logic            done_o;

  typedef enum int {EvHalt, EvReq, EvCeil, EvRstLo, EvRstHi, EvDone, EvInitLo} ev_e;
  typedef struct {
    ev_e         kind;
    logic [63:0] data;
    int          rel;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   t0 = 0;

  fence_t_ctrl u_dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fence_t_i     (fence_t_i),
    .pc_commit_i   (pc_commit_i),
    .boot_addr_i   (boot_addr_i),
    .flush_req_o   (flush_req_o),
    .flush_ack_i   (flush_ack_i),
    .busy_i        (busy_i),
    .pad_i         (pad_i),
    .src_sel_i     (src_sel_i),
    .time_irq_i    (time_irq_i),
    .priv_lvl_i    (priv_lvl_i),
    .halt_o        (halt_o),
    .stall_cache_o (stall_cache_o),
    .rst_uarch_no  (rst_uarch_no),
    .cache_init_no (cache_init_no),
    .rst_addr_o    (rst_addr_o),
    .ceil_o        (ceil_o),
    .ceil_valid_o  (ceil_valid_o),
    .done_o        (done_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push_exp(input ev_e k, input logic [63:0] d, input int rel);
    exp_t e;
    e.kind = k;
    e.data = d;
    e.rel  = rel;
    exp_q.push_back(e);
  endtask

  // Compare an observed event against the oldest expected one.
  task automatic ev(input ev_e k, input logic [63:0] d);
    exp_t e;
    int   rel;
    rel = cyc - t0;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL ev_%s unexpected got data=%0h rel=%0d want none", k.name(), d, rel);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data !== d || e.rel != rel) begin
        n_err++;
        $display("FAIL ev_%s got %s data=%0h rel=%0d want %s data=%0h rel=%0d",
                 e.kind.name(), k.name(), d, rel, e.kind.name(), e.data, e.rel);
      end
    end
  endtask

  // Monitor: turns output changes and pulses into scoreboard events.
  logic [1:0] hs_p = 2'b00;
  logic [1:0] req_p = 2'b00;
  logic       rst_p = 1'b1;
  logic       init_p = 1'b0;
  int         lo_len = 0;
  int         hi_len = 0;

  always @(negedge clk_i) begin
    if ({stall_cache_o, halt_o} != hs_p) ev(EvHalt, 64'({stall_cache_o, halt_o}));
    if (flush_req_o != req_p) ev(EvReq, 64'(flush_req_o));
    if (ceil_valid_o) ev(EvCeil, 64'(ceil_o));
    if (rst_p && !rst_uarch_no) ev(EvRstLo, rst_addr_o);
    if (!rst_p && rst_uarch_no) ev(EvRstHi, 64'(lo_len));
    if (done_o) ev(EvDone, 64'd0);
    if (init_p && !cache_init_no) ev(EvInitLo, 64'(hi_len));
    hs_p   <= {stall_cache_o, halt_o};
    req_p  <= flush_req_o;
    rst_p  <= rst_uarch_no;
    init_p <= cache_init_no;
    lo_len <= rst_uarch_no ? 0 : lo_len + 1;
    hi_len <= cache_init_no ? hi_len + 1 : 0;
  end

  // Drive one fence.t sequence; r counts cycles from the fence pulse.
  task automatic run(input logic [63:0] pc, input int ack1, input int ack0, input int busy,
                     input int priv_u, input int spur, input int n);
    for (int r = 0; r < n; r++) begin
      fence_t_i   = (r == 0) || (r == spur);
      pc_commit_i = (r == spur) ? pc + 64'h100 : pc;
      flush_ack_i = {r == ack1, r == ack0};
      busy_i      = {1'b0, r == busy};
      priv_lvl_i  = (r == priv_u) ? PrivLvlU : PrivLvlM;
      if (r == 0) t0 = cyc;
      tick();
    end
    fence_t_i   = 1'b0;
    flush_ack_i = '0;
    busy_i      = '0;
    priv_lvl_i  = PrivLvlM;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL pending_events got=%0d want=0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  // Common tail: one PAD cycle at p, then 16 reset cycles and 3 hold cycles.
  task automatic push_tail(input logic [63:0] addr, input int p);
    push_exp(EvRstLo, addr, p + 1);
    push_exp(EvHalt, 64'd0, p + 17);
    push_exp(EvRstHi, 64'd16, p + 17);
    push_exp(EvDone, 64'd0, p + 17);
    push_exp(EvInitLo, 64'd19, p + 20);
  endtask

  initial begin
    fence_t_i   = 1'b0;
    pc_commit_i = '0;
    boot_addr_i = 64'h1000;
    flush_ack_i = '0;
    busy_i      = '0;
    pad_i       = '0;
    src_sel_i   = 2'd2;
    time_irq_i  = 1'b0;
    priv_lvl_i  = PrivLvlM;
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();

    chk("rst_halt", 64'(halt_o), 64'd0);
    chk("rst_stall", 64'(stall_cache_o), 64'd0);
    chk("rst_flush_req", 64'(flush_req_o), 64'd0);
    chk("rst_uarch_no", 64'(rst_uarch_no), 64'd1);
    chk("rst_cache_init_no", 64'(cache_init_no), 64'd0);
    chk("rst_ceil_valid", 64'(ceil_valid_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_addr", rst_addr_o, 64'h1000);
    chk("rst_ceil", 64'(ceil_o), 64'd0);

    // Out-of-order acks, no padding: DRAIN at 8, PAD at 24.
    push_exp(EvHalt, 64'd3, 1);
    push_exp(EvReq, 64'd3, 1);
    push_exp(EvReq, 64'd1, 4);
    push_exp(EvReq, 64'd0, 8);
    push_exp(EvCeil, 64'd0, 24);
    push_tail(64'h8000_0004, 24);
    run(64'h8000_0000, 3, 7, -1, -1, -1, 45);
    wait_empty();

    // Busy at idle count 10 restarts the drain; stray fence.t in DRAIN ignored.
    push_exp(EvHalt, 64'd3, 1);
    push_exp(EvReq, 64'd3, 1);
    push_exp(EvReq, 64'd0, 2);
    push_exp(EvCeil, 64'd0, 29);
    push_tail(64'h8000_1004, 29);
    run(64'h8000_1000, 1, 1, 12, -1, 5, 50);
    wait_empty();

    // Timer edge 44 cycles before fence.t: pad_cnt is 40 at drain exit; PC wraps.
    src_sel_i  = 2'd0;
    pad_i      = 32'd100;
    time_irq_i = 1'b1;
    repeat (44) tick();
    push_exp(EvHalt, 64'd3, 1);
    push_exp(EvReq, 64'd3, 1);
    push_exp(EvReq, 64'd0, 2);
    push_exp(EvCeil, 64'd60, 18);
    push_tail(64'h2, 57);
    run(64'hFFFF_FFFF_FFFF_FFFE, 1, 1, -1, -1, -1, 80);
    wait_empty();
    time_irq_i = 1'b0;

    // U-mode exit at cycle 1 loads 20; pad_cnt is 5 at drain exit.
    src_sel_i = 2'd1;
    pad_i     = 32'd20;
    push_exp(EvHalt, 64'd3, 1);
    push_exp(EvReq, 64'd3, 1);
    push_exp(EvReq, 64'd0, 2);
    push_exp(EvCeil, 64'd15, 18);
    push_tail(64'h8000_3004, 22);
    run(64'h8000_3000, 1, 1, -1, 0, -1, 45);
    wait_empty();

    // Reset during FLUSH with ack[0] still pending.
    src_sel_i = 2'd2;
    push_exp(EvHalt, 64'd3, 1);
    push_exp(EvReq, 64'd3, 1);
    push_exp(EvReq, 64'd1, 3);
    push_exp(EvHalt, 64'd0, 4);
    push_exp(EvReq, 64'd0, 4);
    run(64'h8000_4000, 2, -1, -1, -1, -1, 4);
    rst_ni = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    chk("mid_rst_addr", rst_addr_o, 64'h1000);
    chk("mid_rst_ceil", 64'(ceil_o), 64'd0);
    chk("mid_rst_uarch_no", 64'(rst_uarch_no), 64'd1);
    chk("mid_rst_cache_init_no", 64'(cache_init_no), 64'd0);
    chk("mid_rst_flush_req", 64'(flush_req_o), 64'd0);
    wait_empty();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
